control_tablero: RTL and testbench



---
 rtl/control_tablero_if.sv | 22 ++
 rtl/control_tablero.sv | 108 ++++++++++
 tb/tb_control_tablero.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/control_tablero_if.sv
// Snapshot handshake between game logic and the board colour sequencer.
// Game logic is the master; control_tablero is the slave.
interface control_tablero_if;
  logic [63:0] board;
  logic        board_valid;
  logic        board_ready;
  logic        lose_in;

  modport master (
    output board,
    output board_valid,
    output lose_in,
    input  board_ready
  );

  modport slave (
    input  board,
    input  board_valid,
    input  lose_in,
    output board_ready
  );
endinterface

// File: rtl/control_tablero.sv
// Owns the 16 tile-colour registers feeding the VGA board mux and the win/lose flags.
// Accepted snapshots are committed one tile per clock, only while vblank is high.
module control_tablero #(
  parameter logic [3:0]  WIN_EXP   = 4'd11,
  parameter logic [23:0] EMPTY_RGB = 24'hCDC1B4,
  parameter logic [23:0] TOP_RGB   = 24'h3C3A32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic                vblank,
  control_tablero_if.slave    brd,
  output logic [383:0]        rgb_bus,
  output logic                win,
  output logic                lose,
  output logic                busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_VBL = 2'd1;
  localparam logic [1:0] LOAD     = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [63:0] shadow;
  logic        win_acc;
  logic [23:0] tile_rgb [16];
  logic [3:0]  cur_exp;

  function automatic logic [23:0] colour_of(input logic [3:0] e);
    logic [23:0] c;
    case (e)
      4'd0:    c = EMPTY_RGB;
      4'd1:    c = 24'hEEE4DA;
      4'd2:    c = 24'hEDE0C8;
      4'd3:    c = 24'hF2B179;
      4'd4:    c = 24'hF59563;
      4'd5:    c = 24'hF67C5F;
      4'd6:    c = 24'hF65E3B;
      4'd7:    c = 24'hEDCF72;
      4'd8:    c = 24'hEDCC61;
      4'd9:    c = 24'hEDC850;
      4'd10:   c = 24'hEDC53F;
      4'd11:   c = 24'hEDC22E;
      default: c = TOP_RGB;
    endcase
    return c;
  endfunction

  assign cur_exp         = shadow[{idx, 2'b00} +: 4];
  assign brd.board_ready = (state == IDLE);
  assign busy            = (state != IDLE);

  // Restart outranks everything, including a snapshot offered in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      shadow  <= 64'd0;
      win_acc <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
      for (int i = 0; i < 16; i++) tile_rgb[i] <= EMPTY_RGB;
    end else if (restart) begin
      state   <= IDLE;
      idx     <= 4'd0;
      win_acc <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
      for (int i = 0; i < 16; i++) tile_rgb[i] <= EMPTY_RGB;
    end else begin
      case (state)
        IDLE: begin
          if (brd.board_valid) begin
            shadow  <= brd.board;
            win_acc <= 1'b0;
            idx     <= 4'd0;
            state   <= WAIT_VBL;
          end
        end
        WAIT_VBL: begin
          if (vblank) state <= LOAD;
        end
        // Dropping vblank freezes idx, so the commit resumes on the same tile.
        LOAD: begin
          if (vblank) begin
            tile_rgb[idx] <= colour_of(cur_exp);
            win_acc       <= win_acc | (cur_exp == WIN_EXP);
            idx           <= idx + 4'd1;
            if (idx == 4'd15) state <= DONE;
          end
        end
        DONE: begin
          win   <= win_acc;
          lose  <= brd.lose_in & ~win_acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_bus
    assign rgb_bus[24*g +: 24] = tile_rgb[g];
  end

endmodule

// File: tb/tb_control_tablero.sv
// Directed bench for control_tablero: reset, commit latency, colour map, vblank pause,
// restart priority and asynchronous reset mid-commit.
module tb_control_tablero;

  localparam logic [23:0] EMPTY = 24'hCDC1B4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         restart = 1'b0;
  logic         vblank = 1'b0;
  logic [383:0] rgb_bus;
  logic         win, lose, busy;

  int total = 0;
  int bad   = 0;

  control_tablero_if bif ();

  control_tablero dut (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .vblank  (vblank),
    .brd     (bif.slave),
    .rgb_bus (rgb_bus),
    .win     (win),
    .lose    (lose),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] B_ZERO = 64'h0;
  localparam logic [63:0] B_WIN5 = 64'h1111_1111_11B1_1111;
  localparam logic [63:0] B_LOSE = 64'hFEDC_CA98_7654_3210;
  localparam logic [63:0] B_ALT  = 64'h2121_2121_2121_2121;
  localparam logic [63:0] B_RAMP = 64'hA987_A987_A987_A987;
  localparam logic [63:0] B_WALL = 64'hBBBB_BBBB_BBBB_BBBB;

  function automatic logic [23:0] ref_colour(input logic [3:0] e);
    case (e)
      4'd0:  return 24'hCDC1B4;
      4'd1:  return 24'hEEE4DA;
      4'd2:  return 24'hEDE0C8;
      4'd3:  return 24'hF2B179;
      4'd4:  return 24'hF59563;
      4'd5:  return 24'hF67C5F;
      4'd6:  return 24'hF65E3B;
      4'd7:  return 24'hEDCF72;
      4'd8:  return 24'hEDCC61;
      4'd9:  return 24'hEDC850;
      4'd10: return 24'hEDC53F;
      4'd11: return 24'hEDC22E;
      default: return 24'h3C3A32;
    endcase
  endfunction

  // Tiles below n come from new_b, the rest from old_b.
  function automatic logic [383:0] partial(input logic [63:0] new_b, input logic [63:0] old_b,
                                           input int n);
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[24*i +: 24] = (i < n) ? ref_colour(new_b[4*i +: 4]) : ref_colour(old_b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [383:0] exp_rgb(input logic [63:0] b);
    return partial(b, b, 16);
  endfunction

  task automatic check_output(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full commit with vblank held high; board is scrambled after acceptance.
  task automatic apply_stimulus(input logic [63:0] b, input logic li);
    bif.board       = b;
    bif.lose_in     = li;
    bif.board_valid = 1'b1;
    vblank          = 1'b1;
    tick();
    bif.board_valid = 1'b0;
    bif.board       = ~b;
    repeat (18) tick();
  endtask

  int low_cnt;

  initial begin
    bif.board       = '0;
    bif.board_valid = 1'b0;
    bif.lose_in     = 1'b0;

    // Reset values
    #12;
    check_output("reset_rgb", rgb_bus, {16{EMPTY}});
    check_output("reset_flags", {win, lose}, 2'b00);
    check_output("reset_ready", bif.board_ready, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // All-empty board with minimum latency: ready low through E0..E17, high after E18
    bif.board = B_ZERO; bif.board_valid = 1'b1; vblank = 1'b1; bif.lose_in = 1'b0;
    tick();
    bif.board_valid = 1'b0;
    low_cnt = 0;
    if (bif.board_ready == 1'b0) low_cnt++;
    repeat (17) begin
      tick();
      if (bif.board_ready == 1'b0) low_cnt++;
    end
    check_output("latency_ready_low", low_cnt, 18);
    tick();
    check_output("latency_ready_back", bif.board_ready, 1'b1);
    check_output("latency_busy_back", busy, 1'b0);
    check_output("empty_rgb", rgb_bus, {16{EMPTY}});
    check_output("empty_flags", {win, lose}, 2'b00);

    // Win tile at index 5, win outranks lose_in
    apply_stimulus(B_WIN5, 1'b1);
    check_output("win5_rgb", rgb_bus, exp_rgb(B_WIN5));
    check_output("win5_tile5", rgb_bus[24*5 +: 24], 24'hEDC22E);
    check_output("win5_flags", {win, lose}, 2'b10);

    // Every exponent except 11, lose_in high
    apply_stimulus(B_LOSE, 1'b1);
    check_output("lose_rgb", rgb_bus, exp_rgb(B_LOSE));
    check_output("lose_flags", {win, lose}, 2'b01);

    // Accept outside vblank, vblank raised 10 cycles later
    bif.board = B_ALT; bif.board_valid = 1'b1; bif.lose_in = 1'b0; vblank = 1'b0;
    tick();
    bif.board_valid = 1'b0; bif.board = ~B_ALT;
    repeat (10) tick();
    check_output("novbl_rgb_held", rgb_bus, exp_rgb(B_LOSE));
    check_output("novbl_busy", busy, 1'b1);
    vblank = 1'b1;
    tick();
    check_output("vbl_first_edge", rgb_bus, exp_rgb(B_LOSE));
    tick();
    check_output("vbl_tile0", rgb_bus, partial(B_ALT, B_LOSE, 1));
    repeat (16) tick();
    check_output("alt_rgb", rgb_bus, exp_rgb(B_ALT));
    check_output("alt_flags", {win, lose, bif.board_ready}, 3'b001);

    // Pause after tile 7, five cycles low, then resume
    bif.board = B_RAMP; bif.board_valid = 1'b1; vblank = 1'b1;
    tick();
    bif.board_valid = 1'b0; bif.board = ~B_RAMP;
    repeat (9) tick();
    vblank = 1'b0;
    check_output("pause_start", rgb_bus, partial(B_RAMP, B_ALT, 8));
    repeat (5) tick();
    check_output("pause_held", rgb_bus, partial(B_RAMP, B_ALT, 8));
    check_output("pause_busy", busy, 1'b1);
    vblank = 1'b1;
    repeat (7) tick();
    check_output("resume_tile14", rgb_bus, partial(B_RAMP, B_ALT, 15));
    check_output("resume_not_ready", bif.board_ready, 1'b0);
    tick();
    check_output("resume_full", rgb_bus, exp_rgb(B_RAMP));
    tick();
    check_output("resume_ready", bif.board_ready, 1'b1);

    // Restart together with board_valid in IDLE, flags set beforehand
    apply_stimulus(B_WALL, 1'b0);
    check_output("wall_win", {win, lose}, 2'b10);
    bif.board = B_WIN5; bif.board_valid = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0; bif.board_valid = 1'b0;
    check_output("restart_ready", {bif.board_ready, busy}, 2'b10);
    check_output("restart_rgb", rgb_bus, {16{EMPTY}});
    check_output("restart_flags", {win, lose}, 2'b00);
    repeat (3) tick();
    check_output("restart_no_accept", {bif.board_ready, busy}, 2'b10);

    // Asynchronous reset at idx 9 with lose flag set
    apply_stimulus(B_LOSE, 1'b1);
    check_output("prerst_lose", {win, lose}, 2'b01);
    bif.board = B_RAMP; bif.board_valid = 1'b1; vblank = 1'b1;
    tick();
    bif.board_valid = 1'b0;
    repeat (10) tick();
    check_output("prerst_idx9", rgb_bus, partial(B_RAMP, B_LOSE, 9));
    #3 rst = 1'b1;
    #1;
    check_output("async_rst_rgb", rgb_bus, {16{EMPTY}});
    check_output("async_rst_state", {win, lose, bif.board_ready, busy}, 4'b0010);
    rst = 1'b0;
    tick();
    apply_stimulus(B_WIN5, 1'b0);
    check_output("post_rst_rgb", rgb_bus, exp_rgb(B_WIN5));
    check_output("post_rst_flags", {win, lose, bif.board_ready}, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
